// File: rtl/fir3_sched.sv
// Sequencing controller around a 3-parallel FIR: coefficient load/commit, 3-sample packing,
// credit-throttled issue and output re-serialisation. Optional status outputs: FIR3_SCHED_STATUS_EN.
module fir3_sched #(
  parameter int DW          = 8,
  parameter int NTAPS       = 9,
  parameter int OBUF_GROUPS = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CFG_START,
  input  logic                CFG_VALID,
  input  logic [DW-1:0]       CFG_DATA,
  output logic                CFG_DONE,
  output logic                CFG_ERR,
  input  logic                S_VALID,
  input  logic [DW-1:0]       S_DATA,
  output logic                S_READY,
  input  logic                FLUSH,
  output logic [DW-1:0]       F_DIN,
  output logic [DW-1:0]       F_DIN_2,
  output logic [DW-1:0]       F_DIN_3,
  output logic                F_VIN,
  output logic [NTAPS*DW-1:0] H_FLAT,
  input  logic [DW-1:0]       F_DOUT,
  input  logic [DW-1:0]       F_DOUT_2,
  input  logic [DW-1:0]       F_DOUT_3,
  input  logic                F_VOUT,
  output logic                M_VALID,
  output logic [DW-1:0]       M_DATA,
  input  logic                M_READY,
  output logic                BUSY,
`ifdef FIR3_SCHED_STATUS_EN
  output logic                ERR_SPUR,
  output logic [15:0]         GRP_CNT,
`endif
  output logic [1:0]          FSM_STATE
);

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int AW = (OBUF_GROUPS > 1) ? $clog2(OBUF_GROUPS) : 1;
  localparam int CW = $clog2(OBUF_GROUPS + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(OBUF_GROUPS);
  localparam logic [AW-1:0] PTR_LAST   = AW'(OBUF_GROUPS - 1);
  localparam logic [IW-1:0] TAP_LAST   = IW'(NTAPS - 1);

  typedef enum logic [1:0] {UNCFG = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  state_t              state_q, state_d;
  logic [IW-1:0]       tap_idx_q, tap_idx_d;
  logic [DW-1:0]       shadow_q [NTAPS];
  logic [NTAPS*DW-1:0] h_flat_q, shadow_flat;
  logic                cfg_done_q, cfg_err_q;
  logic                shadow_we, commit, cfg_reject, cfg_clear;

  logic [1:0]          pack_cnt_q, a_cnt;
  logic [DW-1:0]       p0_q, p1_q, a_p0, a_p1;
  logic                flush_pend_q, flush_pend_d, flush_req;
  logic                run, s_ready, acc, full, partial, issue;
  logic [DW-1:0]       iss_d0, iss_d1, iss_d2;
  logic [1:0]          iss_n;
  logic [CW-1:0]       credit_q;
  logic                f_vin_q;
  logic [DW-1:0]       f_din0_q, f_din1_q, f_din2_q;

  logic [1:0]          tag_mem [OBUF_GROUPS];
  logic [AW-1:0]       tag_wr_q, tag_rd_q;
  logic [CW-1:0]       tag_cnt_q;
  logic                tag_pop;

  logic [DW-1:0]       ob_d0 [OBUF_GROUPS];
  logic [DW-1:0]       ob_d1 [OBUF_GROUPS];
  logic [DW-1:0]       ob_d2 [OBUF_GROUPS];
  logic [1:0]          ob_n  [OBUF_GROUPS];
  logic [AW-1:0]       ob_wr_q, ob_rd_q;
  logic [CW-1:0]       ob_cnt_q;
  logic [1:0]          u_idx_q;
  logic                m_valid, m_fire, pop_last;
  logic [DW-1:0]       m_data;
  logic                busy;

  // Valid/ready: a transfer happens on the rising edge where VALID and READY are both high;
  // the source holds VALID and DATA stable until that edge.
  assign run     = (state_q == RUN);
  assign s_ready = run & ((pack_cnt_q != 2'd2) | (credit_q != '0));
  assign acc     = S_VALID & s_ready;
  assign m_valid = (ob_cnt_q != '0);
  assign m_fire  = m_valid & M_READY;
  assign tag_pop = F_VOUT & (tag_cnt_q != '0);
  assign busy    = (pack_cnt_q != 2'd0) | (tag_cnt_q != '0) | (ob_cnt_q != '0);

  always_comb begin : fsm_comb
    state_d    = state_q;
    tap_idx_d  = tap_idx_q;
    shadow_we  = 1'b0;
    commit     = 1'b0;
    cfg_reject = 1'b0;
    cfg_clear  = 1'b0;
    case (state_q)
      UNCFG: begin
        if (CFG_START) begin
          state_d   = LOAD;
          tap_idx_d = '0;
        end
      end
      LOAD: begin
        if (CFG_START) begin
          tap_idx_d = '0;
        end else if (CFG_VALID) begin
          shadow_we = 1'b1;
          if (tap_idx_q == TAP_LAST) begin
            commit    = 1'b1;
            state_d   = RUN;
            tap_idx_d = '0;
          end else begin
            tap_idx_d = tap_idx_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (CFG_START) begin
          if (busy) begin
            cfg_reject = 1'b1;
          end else begin
            state_d   = LOAD;
            tap_idx_d = '0;
            cfg_clear = 1'b1;
          end
        end
      end
      default: state_d = UNCFG;
    endcase
  end

  // The word arriving with the commit goes straight into the top tap.
  always_comb begin : commit_comb
    shadow_flat = '0;
    for (int i = 0; i < NTAPS - 1; i++) shadow_flat[i*DW +: DW] = shadow_q[i];
    shadow_flat[(NTAPS-1)*DW +: DW] = CFG_DATA;
  end

  always_comb begin : pack_comb
    a_cnt = pack_cnt_q;
    a_p0  = p0_q;
    a_p1  = p1_q;
    full  = 1'b0;
    if (acc) begin
      case (pack_cnt_q)
        2'd0:    begin a_p0 = S_DATA; a_cnt = 2'd1; end
        2'd1:    begin a_p1 = S_DATA; a_cnt = 2'd2; end
        default: begin full = 1'b1;   a_cnt = 2'd0; end
      endcase
    end
    // Flush acts on the group as it stands after this cycle's accept.
    flush_req    = (FLUSH | flush_pend_q) & run;
    partial      = flush_req & (a_cnt != 2'd0) & (credit_q != '0);
    flush_pend_d = flush_req & (a_cnt != 2'd0) & (credit_q == '0);
    issue        = full | partial;
    iss_d0       = full ? p0_q : a_p0;
    iss_d1       = full ? p1_q : ((a_cnt == 2'd2) ? a_p1 : '0);
    iss_d2       = full ? S_DATA : '0;
    iss_n        = full ? 2'd3 : a_cnt;
  end

  always_comb begin : unpack_comb
    pop_last = m_fire & (u_idx_q == (ob_n[ob_rd_q] - 2'd1));
    m_data   = '0;
    if (m_valid) begin
      case (u_idx_q)
        2'd0:    m_data = ob_d0[ob_rd_q];
        2'd1:    m_data = ob_d1[ob_rd_q];
        default: m_data = ob_d2[ob_rd_q];
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (shadow_we) shadow_q[tap_idx_q] <= CFG_DATA;
    if (issue) tag_mem[tag_wr_q] <= iss_n;
    if (tag_pop) begin
      ob_d0[ob_wr_q] <= F_DOUT;
      ob_d1[ob_wr_q] <= F_DOUT_2;
      ob_d2[ob_wr_q] <= F_DOUT_3;
      ob_n[ob_wr_q]  <= tag_mem[tag_rd_q];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= UNCFG;
      tap_idx_q    <= '0;
      h_flat_q     <= '0;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      pack_cnt_q   <= 2'd0;
      p0_q         <= '0;
      p1_q         <= '0;
      flush_pend_q <= 1'b0;
      credit_q     <= CREDIT_MAX;
      f_vin_q      <= 1'b0;
      f_din0_q     <= '0;
      f_din1_q     <= '0;
      f_din2_q     <= '0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      tag_cnt_q    <= '0;
      ob_wr_q      <= '0;
      ob_rd_q      <= '0;
      ob_cnt_q     <= '0;
      u_idx_q      <= 2'd0;
    end else begin
      state_q   <= state_d;
      tap_idx_q <= tap_idx_d;
      cfg_err_q <= cfg_reject;
      if (commit) begin
        h_flat_q   <= shadow_flat;
        cfg_done_q <= 1'b1;
      end else if (cfg_clear) begin
        cfg_done_q <= 1'b0;
      end
      pack_cnt_q   <= partial ? 2'd0 : a_cnt;
      p0_q         <= a_p0;
      p1_q         <= a_p1;
      flush_pend_q <= flush_pend_d;
      f_vin_q      <= issue;
      if (issue) begin
        f_din0_q <= iss_d0;
        f_din1_q <= iss_d1;
        f_din2_q <= iss_d2;
        tag_wr_q <= ptr_inc(tag_wr_q);
      end
      if (tag_pop) tag_rd_q <= ptr_inc(tag_rd_q);
      case ({issue, tag_pop})
        2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
        2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
        default: tag_cnt_q <= tag_cnt_q;
      endcase
      // A group's credit comes back once its last valid sample leaves the buffer.
      if (issue && !pop_last) begin
        credit_q <= credit_q - 1'b1;
      end else if (pop_last && !issue && (credit_q != CREDIT_MAX)) begin
        credit_q <= credit_q + 1'b1;
      end
      if (tag_pop) ob_wr_q <= ptr_inc(ob_wr_q);
      if (pop_last) ob_rd_q <= ptr_inc(ob_rd_q);
      case ({tag_pop, pop_last})
        2'b10:   ob_cnt_q <= ob_cnt_q + 1'b1;
        2'b01:   ob_cnt_q <= ob_cnt_q - 1'b1;
        default: ob_cnt_q <= ob_cnt_q;
      endcase
      if (pop_last)    u_idx_q <= 2'd0;
      else if (m_fire) u_idx_q <= u_idx_q + 2'd1;
    end
  end

`ifdef FIR3_SCHED_STATUS_EN
  logic        err_spur_q;
  logic [15:0] grp_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_spur_q <= 1'b0;
      grp_cnt_q  <= 16'd0;
    end else begin
      if (F_VOUT && (tag_cnt_q == '0)) err_spur_q <= 1'b1;
      if (issue) grp_cnt_q <= grp_cnt_q + 16'd1;
    end
  end

  assign ERR_SPUR = err_spur_q;
  assign GRP_CNT  = grp_cnt_q;
`endif

  assign CFG_DONE  = cfg_done_q;
  assign CFG_ERR   = cfg_err_q;
  assign S_READY   = s_ready;
  assign F_VIN     = f_vin_q;
  assign F_DIN     = f_din0_q;
  assign F_DIN_2   = f_din1_q;
  assign F_DIN_3   = f_din2_q;
  assign H_FLAT    = h_flat_q;
  assign M_VALID   = m_valid;
  assign M_DATA    = m_data;
  assign BUSY      = busy;
  assign FSM_STATE = state_q;

endmodule

// File: tb/tb_fir3_sched.sv
// Directed bench for fir3_sched: FIR stub with 2-cycle echo, group and output scoreboards.
module tb_fir3_sched;
  localparam int DW = 8;
  localparam int NTAPS = 9;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_start = 1'b0, cfg_valid = 1'b0;
  logic [DW-1:0]       cfg_data = '0;
  logic                cfg_done, cfg_err;
  logic                s_valid = 1'b0;
  logic [DW-1:0]       s_data = '0;
  logic                s_ready;
  logic                flush = 1'b0;
  logic [DW-1:0]       f_din, f_din_2, f_din_3;
  logic                f_vin;
  logic [NTAPS*DW-1:0] h_flat;
  logic [DW-1:0]       f_dout, f_dout_2, f_dout_3;
  logic                f_vout;
  logic                m_valid;
  logic [DW-1:0]       m_data;
  logic                m_ready = 1'b0;
  logic                busy;
  logic [1:0]          fsm_state;
`ifdef FIR3_SCHED_STATUS_EN
  logic                err_spur;
  logic [15:0]         grp_cnt;
`endif

  fir3_sched #(.DW(DW), .NTAPS(NTAPS), .OBUF_GROUPS(4)) dut (
    .CLK(clk), .RST(rst),
    .CFG_START(cfg_start), .CFG_VALID(cfg_valid), .CFG_DATA(cfg_data),
    .CFG_DONE(cfg_done), .CFG_ERR(cfg_err),
    .S_VALID(s_valid), .S_DATA(s_data), .S_READY(s_ready), .FLUSH(flush),
    .F_DIN(f_din), .F_DIN_2(f_din_2), .F_DIN_3(f_din_3), .F_VIN(f_vin), .H_FLAT(h_flat),
    .F_DOUT(f_dout), .F_DOUT_2(f_dout_2), .F_DOUT_3(f_dout_3), .F_VOUT(f_vout),
    .M_VALID(m_valid), .M_DATA(m_data), .M_READY(m_ready), .BUSY(busy),
`ifdef FIR3_SCHED_STATUS_EN
    .ERR_SPUR(err_spur), .GRP_CNT(grp_cnt),
`endif
    .FSM_STATE(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // FIR stub: echoes the issued group two cycles later
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [23:0] d1 = '0, d2 = '0;
  always @(posedge clk) begin
    v1 <= f_vin;
    d1 <= {f_din, f_din_2, f_din_3};
    v2 <= v1;
    d2 <= d1;
  end
  assign f_vout   = v2;
  assign f_dout   = d2[23:16];
  assign f_dout_2 = d2[15:8];
  assign f_dout_3 = d2[7:0];

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [23:0]   exp_grp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int grp_seen = 0;
  int mv_seen = 0;

  localparam logic [71:0] H_A = 72'h090807060504030201;
  localparam logic [71:0] H_B = 72'h191817161514131211;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) mv_seen++;
    if (f_vin) begin
      grp_seen++;
      if (exp_grp_q.size() == 0) check("grp_extra", {f_din, f_din_2, f_din_3}, 0);
      else check("grp", {f_din, f_din_2, f_din_3}, exp_grp_q.pop_front());
    end
    if (m_valid && m_ready && !rst) begin
      if (exp_q.size() == 0) check("out_extra", m_data, 0);
      else check("out", m_data, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    check("send_ready_wait", (n < 200), 1);
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_grp_q.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    check("drain_out", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  task automatic load_coeffs(input logic [DW-1:0] base);
    cfg_valid = 1'b1;
    for (int i = 0; i < NTAPS; i++) begin
      cfg_data = base + DW'(i);
      if (i == NTAPS - 1) check("pre_commit_done", cfg_done, 0);
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_cfg_done", cfg_done, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_h_flat", h_flat, 0);
    check("rst_f_vin", f_vin, 0);
    check("rst_state", fsm_state, 0);
    rst = 1'b0;
    tick();

    // coefficient load 1..9
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("load_state", fsm_state, 1);
    load_coeffs(8'd1);
    check("load_done", cfg_done, 1);
    check("load_h_flat", h_flat, H_A);
    check("load_state_run", fsm_state, 2);
    check("run_s_ready", s_ready, 1);

    // streaming 1..6
    m_ready = 1'b1;
    exp_grp_q.push_back(24'h010203);
    exp_grp_q.push_back(24'h040506);
    for (int i = 1; i <= 6; i++) exp_q.push_back(DW'(i));
    for (int i = 1; i <= 6; i++) send(DW'(i));
    s_valid = 1'b0;
    wait_idle();
    check("stream_grps", grp_seen, 2);

    // flush of a partial group
    exp_grp_q.push_back(24'h070800);
    exp_q.push_back(8'd7);
    exp_q.push_back(8'd8);
    send(8'd7);
    send(8'd8);
    s_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle();
    check("flush_grps", grp_seen, 3);

    // backpressure: all four credits must be available again
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      exp_grp_q.push_back({DW'(11 + 3*i), DW'(12 + 3*i), DW'(13 + 3*i)});
    exp_grp_q.push_back(24'h171819);
    for (int i = 11; i <= 25; i++) exp_q.push_back(DW'(i));
    for (int i = 0; i < 14; i++) send(DW'(11 + i));
    s_valid = 1'b1;
    s_data  = 8'd25;
    repeat (6) tick();
    check("bp_s_ready", s_ready, 0);
    check("bp_grps", grp_seen, 7);
    check("bp_m_valid", m_valid, 1);
    check("bp_m_data_hold", m_data, 11);
    m_ready = 1'b1;
    send(8'd25);
    s_valid = 1'b0;
    wait_idle();
    check("bp_grps_final", grp_seen, 8);

    // CFG_START while busy is rejected
    send(8'd30);
    s_valid = 1'b0;
    check("busy_pack", busy, 1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_err_state", fsm_state, 2);
    tick();
    check("cfg_err_clear", cfg_err, 0);
    check("cfg_err_h_flat", h_flat, H_A);
    exp_grp_q.push_back(24'h1e0000);
    exp_q.push_back(8'd30);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle();

    // reload when idle, restart after four words
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("reload_state", fsm_state, 1);
    check("reload_done_clr", cfg_done, 0);
    check("reload_s_ready", s_ready, 0);
    cfg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_data = 8'ha1 + DW'(i);
      tick();
    end
    cfg_valid = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("restart_h_hold", h_flat, H_A);
    load_coeffs(8'h11);
    check("restart_h_flat", h_flat, H_B);
    check("restart_done", cfg_done, 1);
    check("restart_state", fsm_state, 2);

    // reset with two flushed groups in flight
    exp_grp_q.push_back(24'h410000);
    exp_grp_q.push_back(24'h420000);
    s_valid = 1'b1;
    s_data  = 8'h41;
    flush   = 1'b1;
    tick();
    s_data  = 8'h42;
    tick();
    s_valid = 1'b0;
    flush   = 1'b0;
    rst     = 1'b1;
    tick();
    check("mid_rst_state", fsm_state, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_f_vin", f_vin, 0);
    check("mid_rst_f_din", {f_din, f_din_2, f_din_3}, 0);
    check("mid_rst_h_flat", h_flat, 0);
    check("mid_rst_cfg_done", cfg_done, 0);
    check("mid_rst_m_valid", m_valid, 0);
    rst = 1'b0;
    mv_seen = 0;
    repeat (10) tick();
    check("post_rst_no_mvalid", mv_seen, 0);
    check("post_rst_grps", exp_grp_q.size(), 0);
`ifdef FIR3_SCHED_STATUS_EN
    check("post_rst_err_spur", err_spur, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fir3_sched.md
# fir3_sched

Sequencing controller for the 3-parallel, 9-tap, 8-bit FIR datapath.
- Loads and atomically commits the nine coefficients from a serial configuration port.
- Packs a serial valid/ready sample stream into 3-sample groups and issues each group with a one-cycle `VIN` pulse.
- Buffers the FIR's 3-wide `VOUT` results and re-serialises them to a valid/ready output stream.
- The FIR has no backpressure, so issue is throttled by output-buffer credits. The block sits between the system stream interfaces and the FIR core.

## Interface
Parameters:
- `DW`, 8, sample and coefficient width.
- `NTAPS`, 9, number of coefficients.
- `OBUF_GROUPS`, 4, output buffer depth in 3-sample groups; also the credit count.

Ports:
- `CLK`  in  1  clock, rising edge. One clock domain.
- `RST`  in  1  reset, synchronous, active-high.
- `CFG_START`  in  1  start a coefficient load.
- `CFG_VALID`  in  1  coefficient word valid.
- `CFG_DATA`  in  DW  coefficient word, H0 first.
- `CFG_DONE`  out  1  committed coefficients are valid.
- `CFG_ERR`  out  1  one-cycle pulse: `CFG_START` rejected.
- `S_VALID`  in  1  input sample valid.
- `S_DATA`  in  DW  input sample.
- `S_READY`  out  1  input sample accepted when `S_VALID & S_READY`.
- `FLUSH`  in  1  issue the partial group, zero-padded.
- `F_DIN`, `F_DIN_2`, `F_DIN_3`  out  DW  group to FIR; oldest sample in `F_DIN`.
- `F_VIN`  out  1  group valid to FIR.
- `H_FLAT`  out  NTAPS*DW  coefficients; H0 in bits [DW-1:0].
- `F_DOUT`, `F_DOUT_2`, `F_DOUT_3`  in  DW  FIR results.
- `F_VOUT`  in  1  FIR result valid.
- `M_VALID`  out  1  output sample valid.
- `M_DATA`  out  DW  output sample.
- `M_READY`  in  1  output sample taken when `M_VALID & M_READY`.
- `BUSY`  out  1  any sample is packed, in flight or buffered.

## Operation
State machine:
- **UNCFG** (reset state) → **LOAD** on `CFG_START`.
- **LOAD**: each `CFG_VALID` writes the next shadow tap (H0..H8). On the 9th word, shadow commits to `H_FLAT`, `CFG_DONE`=1 and the state goes to **RUN**. `CFG_START` in LOAD restarts at H0.
- **RUN**: when `BUSY`=0, `CFG_START` goes to LOAD and clears `CFG_DONE`; `H_FLAT` holds its old value until the commit. When `BUSY`=1, `CFG_START` is ignored and `CFG_ERR` pulses.

Packing (RUN only):
- `pack_cnt` ranges 0..2.
- `S_READY` = RUN & (`pack_cnt`<2 | `credit`>0).
- Accepting the 3rd sample issues the group and decrements `credit`.

`FLUSH`:
- Applies after any sample accepted in the same cycle.
- If `pack_cnt`>0 and `credit`>0: issue the group with empty slots = 0, then clear `pack_cnt`.
- If `credit`=0: hold the request until a credit returns.
- If `pack_cnt`=0: no-op.

Tag FIFO (depth `OBUF_GROUPS`):
- Pushes the valid count (1..3) at each issue.
- Pops at each `F_VOUT`, which writes the 3 results plus the count into the output buffer.

Unpacker:
- Emits `F_DOUT`, then `F_DOUT_2`, then `F_DOUT_3`, dropping padded slots.
- After the last valid sample of a group is popped, `credit` is incremented.
- `credit` is reset to `OBUF_GROUPS` and is never incremented above it.

Arithmetic: no computation on data; packer and unpacker only move samples and apply zero padding.

## Timing
- Reset values:
  - All outputs 0, including `H_FLAT`, `CFG_DONE`, `S_READY`, `F_VIN`, `F_DIN*`, `M_VALID`, `M_DATA`, `BUSY`.
  - State UNCFG; `credit` = `OBUF_GROUPS`; buffers empty.
  - Reset mid-stream discards all packed, in-flight and buffered data.
- `CFG_DONE` and `H_FLAT` update in the cycle after the edge that accepts the 9th word.
- Issue timing: group completion or flush accepted at edge k gives `F_VIN`=1 with registered `F_DIN*` during cycle k+1, for exactly one cycle. `F_DIN*` then hold.
- `F_VOUT` at edge e gives `M_VALID`=1 in cycle e+1 if the buffer was empty. `M_DATA` is stable while `M_VALID & !M_READY`.
- Sustained throughput: 1 sample/cycle in and out, provided `OBUF_GROUPS` covers FIR latency + 1.
- Simultaneous credit return and issue in the same cycle: net `credit` is unchanged.

## Configuration
- Macro `FIR3_SCHED_STATUS_EN`.
- When defined, adds two outputs:
  - `ERR_SPUR` (1 bit): sticky; set by `F_VOUT` when the tag FIFO is empty; cleared only by `RST`.
  - `GRP_CNT` (16 bit): wrapping count of issued groups.
- When undefined, neither port exists and a spurious `F_VOUT` is silently ignored.

## Test plan
Unless stated otherwise, a stub echoes `F_DIN*` to `F_DOUT*` 2 cycles after `F_VIN`.
- **Coefficient load**: `CFG_START`, then words 1..9 → `CFG_DONE`=1 one cycle after the 9th word; `H_FLAT`[7:0]=1 … [71:64]=9; state RUN.
- **Streaming**: samples 1..6 back-to-back with `M_READY`=1 → two `F_VIN` pulses carrying (1,2,3) and (4,5,6); `M_DATA` = 1..6 in order; `BUSY` returns to 0.
- **Backpressure**: `M_READY`=0, offer 15 samples → 14 accepted, `S_READY`=0 from then on, 4 groups issued. Raise `M_READY` → 15th sample accepted; 15 outputs in order.
- **Flush**: samples 7, 8, then `FLUSH` → `F_VIN` with (7,8,0); `M_DATA` emits 7 and 8 only; `credit` restored to 4.
- **Config boundaries**:
  - `CFG_START` with `BUSY`=1 → `CFG_ERR` pulse; `H_FLAT` unchanged.
  - `CFG_START` after 4 words in LOAD → load restarts at H0; old `H_FLAT` held until the 9th new word.
- **Reset**: `RST` mid-stream with 2 groups in flight → all outputs 0 next cycle; state UNCFG; later stub `F_VOUT` produces no `M_VALID` (and sets `ERR_SPUR` with `FIR3_SCHED_STATUS_EN`).
